// File: rtl/fp_add_pkg.sv
// fp_add_pkg: shared definitions for the FP add issue queue slice.
// Holds the FP32 word width and field-slice positions, plus the default
// adder latency, result FIFO depth and tag width used by the top and FIFO.
package fp_add_pkg;

   localparam int FP32_W        = 32;
   localparam int FP32_SIGN_BIT = 31;
   localparam int FP32_EXP_MSB  = 30;
   localparam int FP32_EXP_LSB  = 23;
   localparam int FP32_MAN_MSB  = 22;
   localparam int FP32_MAN_LSB  = 0;

   localparam int DEFAULT_LATENCY = 4;
   localparam int DEFAULT_DEPTH   = 8;
   localparam int DEFAULT_TAG_W   = 4;

   typedef logic [FP32_W-1:0] fp32_t;

endpackage

// File: rtl/fp_result_fifo.sv
// fp_result_fifo: circular result FIFO holding {sum, tag} pairs.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   push, push_sum/tag    write one entry at the tail
//   out_ready             consumer takes the head entry when out_valid
//   out_valid             FIFO is non-empty
//   out_sum, out_tag      head entry (zero while empty)
//   count                 current occupancy, 0..DEPTH
// A pushed entry only becomes visible after the clock edge (no bypass).
module fp_result_fifo
   import fp_add_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int TAG_W = DEFAULT_TAG_W,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [FP32_W-1:0] push_sum,
   input  logic [TAG_W-1:0]  push_tag,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [FP32_W-1:0] out_sum,
   output logic [TAG_W-1:0]  out_tag,
   output logic [CNT_W-1:0]  count
);

   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [FP32_W-1:0] sum_mem_q [DEPTH];
   logic [FP32_W-1:0] sum_mem_d [DEPTH];
   logic [TAG_W-1:0]  tag_mem_q [DEPTH];
   logic [TAG_W-1:0]  tag_mem_d [DEPTH];
   logic              pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready;
   assign count     = count_q;

   // Head outputs are forced to zero while empty so reset and drained
   // states never expose stale storage.
   assign out_sum = out_valid ? sum_mem_q[rd_ptr_q] : '0;
   assign out_tag = out_valid ? tag_mem_q[rd_ptr_q] : '0;

   always_comb begin
      sum_mem_d = sum_mem_q;
      tag_mem_d = tag_mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (push) begin
         sum_mem_d[wr_ptr_q] = push_sum;
         tag_mem_d[wr_ptr_q] = push_tag;
         wr_ptr_d            = next_ptr(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
      // Push and pop together leave occupancy unchanged, including when full.
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            sum_mem_q[i] <= '0;
            tag_mem_q[i] <= '0;
         end
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         sum_mem_q <= sum_mem_d;
         tag_mem_q <= tag_mem_d;
      end
   end

   // The issue credit rule makes a push into a full FIFO unreachable.
   push_into_full: assert property (@(posedge clk) disable iff (reset)
      !(push && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/fp_add_issue_queue.sv
// fp_add_issue_queue: issues operand pairs to an external fixed-latency FP
// adder and collects results, in issue order, into a result FIFO.
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   in_valid/in_ready             operand handshake; in_a, in_b, in_tag
//   add_a, add_b                  operands to the adder (zero when not issuing)
//   add_result                    adder output, LATENCY cycles after issue
//   out_valid/out_ready           result handshake; out_sum, out_tag
// Credits: an operation is only accepted while FIFO occupancy plus in-flight
// operations is below DEPTH, so every result is guaranteed a FIFO slot.
module fp_add_issue_queue
   import fp_add_pkg::*;
#(
   parameter int LATENCY = DEFAULT_LATENCY,
   parameter int DEPTH   = DEFAULT_DEPTH,
   parameter int TAG_W   = DEFAULT_TAG_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FP32_W-1:0] in_a,
   input  logic [FP32_W-1:0] in_b,
   input  logic [TAG_W-1:0]  in_tag,
   output logic [FP32_W-1:0] add_a,
   output logic [FP32_W-1:0] add_b,
   input  logic [FP32_W-1:0] add_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [FP32_W-1:0] out_sum,
   output logic [TAG_W-1:0]  out_tag
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [LATENCY-1:0] valid_sr_q, valid_sr_d;
   logic [TAG_W-1:0]   tag_sr_q [LATENCY];
   logic [TAG_W-1:0]   tag_sr_d [LATENCY];
   logic [CNT_W-1:0]   inflight_q, inflight_d;
   logic [CNT_W-1:0]   fifo_count;
   logic [CNT_W:0]     credit_used;
   logic               issue;
   logic               push;

   // Credit check depends only on registered state, never on out_ready.
   assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_q};
   assign in_ready    = (credit_used < (CNT_W + 1)'(DEPTH));
   assign issue       = in_valid && in_ready && !reset;

   assign add_a = issue ? in_a : '0;
   assign add_b = issue ? in_b : '0;

   // The oldest shift-register stage lines up with add_result.
   assign push = valid_sr_q[LATENCY-1];

   always_comb begin
      valid_sr_d    = '0;
      tag_sr_d      = tag_sr_q;
      valid_sr_d[0] = issue;
      tag_sr_d[0]   = in_tag;
      for (int i = 1; i < LATENCY; i++) begin
         valid_sr_d[i] = valid_sr_q[i-1];
         tag_sr_d[i]   = tag_sr_q[i-1];
      end
      case ({issue, push})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_sr_q <= '0;
         inflight_q <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            tag_sr_q[i] <= '0;
         end
      end else begin
         valid_sr_q <= valid_sr_d;
         inflight_q <= inflight_d;
         tag_sr_q   <= tag_sr_d;
      end
   end

   fp_result_fifo #(
      .DEPTH (DEPTH),
      .TAG_W (TAG_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_sum  (add_result),
      .push_tag  (tag_sr_q[LATENCY-1]),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_sum   (out_sum),
      .out_tag   (out_tag),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_fp_add_issue_queue.sv
// tb_fp_add_issue_queue: self-checking bench for fp_add_issue_queue with a
// fixed-latency integer-add stub standing in for the FP adder.
module tb_fp_add_issue_queue;

   localparam int L  = 4;
   localparam int D  = 8;
   localparam int TW = 4;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_a;
   logic [31:0]   in_b;
   logic [TW-1:0] in_tag;
   logic [31:0]   add_a;
   logic [31:0]   add_b;
   logic [31:0]   add_result;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_sum;
   logic [TW-1:0] out_tag;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0]   sum;
      logic [TW-1:0] tag;
      int            due;
   } pend_t;

   typedef struct {
      logic [31:0]   sum;
      logic [TW-1:0] tag;
   } res_t;

   typedef struct {
      logic          v;
      logic [31:0]   a;
      logic [31:0]   b;
      logic [TW-1:0] tag;
      logic          ordy;
      logic          exp_ready;
      logic          exp_valid;
      logic [31:0]   exp_sum;
      logic [TW-1:0] exp_tag;
   } vec_t;

   // Reference model state: operations waiting on the adder and the queue
   // of completed results, both in issue order.
   pend_t pend_q[$];
   res_t  fifo_m[$];
   int    cyc = 0;
   bit    model_on = 0;

   logic [31:0] stub_pipe [L];

   fp_add_issue_queue #(
      .LATENCY (L),
      .DEPTH   (D),
      .TAG_W   (TW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_tag     (in_tag),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_result (add_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sum    (out_sum),
      .out_tag    (out_tag)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Adder stand-in: integer sum of the operands, delivered L cycles later,
   // cleared by the same reset as the DUT.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < L; i++) stub_pipe[i] <= '0;
      end else begin
         stub_pipe[0] <= add_a + add_b;
         for (int i = 1; i < L; i++) stub_pipe[i] <= stub_pipe[i-1];
      end
   end
   assign add_result = stub_pipe[L-1];

   // Drive one cycle of inputs at the falling edge and let them settle.
   task automatic applyStimulus(input logic rst, input logic v, input logic [31:0] a,
                                input logic [31:0] b, input logic [TW-1:0] t,
                                input logic ordy);
      @(negedge clk);
      reset     = rst;
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      in_tag    = t;
      out_ready = ordy;
      #1;
   endtask

   // Single comparison; counts every check and every failure.
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Compare the DUT against the reference model for the current cycle, then
   // cross the rising edge and advance the model by the same rules.
   task automatic modelStep();
      logic        exp_ready;
      logic        exp_issue;
      logic        exp_pop;
      logic [31:0] sum_now;
      res_t        r;
      exp_ready = (fifo_m.size() + pend_q.size()) < D;
      exp_issue = in_valid && exp_ready && !reset;
      exp_pop   = (fifo_m.size() != 0) && out_ready;
      sum_now   = in_a + in_b;
      if (model_on) begin
         checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
         checkOutput("out_valid", 32'(out_valid), 32'(fifo_m.size() != 0));
         if (fifo_m.size() != 0) begin
            checkOutput("out_sum", out_sum, fifo_m[0].sum);
            checkOutput("out_tag", 32'(out_tag), 32'(fifo_m[0].tag));
         end else begin
            checkOutput("out_sum_idle", out_sum, 32'h0);
            checkOutput("out_tag_idle", 32'(out_tag), 32'h0);
         end
         checkOutput("add_a", add_a, exp_issue ? in_a : 32'h0);
         checkOutput("add_b", add_b, exp_issue ? in_b : 32'h0);
      end
      @(posedge clk);
      if (reset) begin
         pend_q.delete();
         fifo_m.delete();
         model_on = 1;
      end else begin
         if (exp_pop) void'(fifo_m.pop_front());
         if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
            r.sum = pend_q[0].sum;
            r.tag = pend_q[0].tag;
            void'(pend_q.pop_front());
            fifo_m.push_back(r);
         end
         if (exp_issue) pend_q.push_back('{sum_now, in_tag, cyc + L});
      end
      cyc++;
   endtask

   task automatic doCycle(input logic rst, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic [TW-1:0] t, input logic ordy);
      applyStimulus(rst, v, a, b, t, ordy);
      modelStep();
   endtask

   // Main sequence: reset, vector table, hand-written corner cases, random run.
   initial begin
      vec_t vecs[7];
      int   next_tag;
      int   accepted;

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_tag    = '0;
      out_ready = 1'b0;

      doCycle(1, 1, 32'h1234, 32'h5678, 4'h1, 0);
      doCycle(1, 0, 0, 0, 0, 0);

      // Single operation: result visible exactly L+1 cycles after issue.
      vecs[0] = '{1, 32'h3F800000, 32'h40000000, 4'd3, 0, 1, 0, 32'h0, 4'd0};
      vecs[1] = '{0, 32'h0, 32'h0, 4'd0, 0, 1, 0, 32'h0, 4'd0};
      vecs[2] = '{0, 32'h0, 32'h0, 4'd0, 0, 1, 0, 32'h0, 4'd0};
      vecs[3] = '{0, 32'h0, 32'h0, 4'd0, 0, 1, 0, 32'h0, 4'd0};
      vecs[4] = '{0, 32'h0, 32'h0, 4'd0, 0, 1, 0, 32'h0, 4'd0};
      vecs[5] = '{0, 32'h0, 32'h0, 4'd0, 1, 1, 1, 32'h7F800000, 4'd3};
      vecs[6] = '{0, 32'h0, 32'h0, 4'd0, 1, 1, 0, 32'h0, 4'd0};
      for (int i = 0; i < 7; i++) begin
         applyStimulus(0, vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].ordy);
         checkOutput($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
         checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
         checkOutput($sformatf("vec%0d_sum", i), out_sum, vecs[i].exp_sum);
         checkOutput($sformatf("vec%0d_tag", i), 32'(out_tag), 32'(vecs[i].exp_tag));
         modelStep();
      end

      // Streaming: 16 back-to-back issues with the consumer always ready.
      next_tag = 0;
      for (int i = 0; i < 16 + L + 2; i++) begin
         if (i < 16) applyStimulus(0, 1, $urandom, $urandom, TW'(i), 1);
         else        applyStimulus(0, 0, 0, 0, 0, 1);
         if (i < 16) checkOutput("stream_ready", 32'(in_ready), 32'h1);
         if (out_valid && out_ready) begin
            checkOutput("stream_order", 32'(out_tag), 32'(next_tag));
            next_tag++;
         end
         modelStep();
      end
      checkOutput("stream_count", 32'(next_tag), 32'd16);

      // Backpressure: consumer stalled, producer always offering.
      accepted = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(0, 1, $urandom, $urandom, TW'($urandom), 0);
         if (in_ready) accepted++;
         if (i == 19) checkOutput("bp_ready_low", 32'(in_ready), 32'h0);
         modelStep();
      end
      checkOutput("bp_accepted", 32'(accepted), 32'(D));

      // Full FIFO drain and refill, three rounds so both pointers wrap.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < D; i++) begin
            applyStimulus(0, 1, $urandom, $urandom, TW'($urandom), 1);
            if (i == 0) begin
               checkOutput("full_ready", 32'(in_ready), 32'h0);
               checkOutput("full_valid", 32'(out_valid), 32'h1);
            end
            modelStep();
         end
         for (int i = 0; i < L + 3; i++) begin
            doCycle(0, 1, $urandom, $urandom, TW'($urandom), 0);
         end
      end

      // Reset with three results in flight and two queued.
      doCycle(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) doCycle(0, 1, $urandom, $urandom, TW'(i), 0);
      doCycle(0, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 32'hDEAD, 32'hBEEF, 4'd9, 0);
      checkOutput("rst_queued_valid", 32'(out_valid), 32'h1);
      checkOutput("rst_no_issue", add_a, 32'h0);
      modelStep();
      for (int i = 0; i < L + 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 1);
         checkOutput("rst_no_stale", 32'(out_valid), 32'h0);
         modelStep();
      end

      // Randomized traffic with occasional resets, checked by the model.
      for (int i = 0; i < 400; i++) begin
         doCycle(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) < 7),
                 $urandom, $urandom, TW'($urandom),
                 ($urandom_range(0, 9) < 5));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
